// File: rtl/tx_traffic_classifier.sv
// rtl/tx_traffic_classifier.sv - per-frame 802.1Q PCP steering of one AXI-S flow to AV or legacy MAC FIFO.
// Optional frame counters: define TX_CLASSIFIER_STATS_EN.
module tx_traffic_classifier #(
  parameter int          HDR_LEN     = 16,
  parameter logic [15:0] VLAN_TPID   = 16'h8100,
  parameter logic [7:0]  AV_PCP_MASK = 8'b0000_1100
) (
  input  logic        tx_mac_aclk,
  input  logic        tx_reset,
  input  logic [7:0]  tx_axis_in_tdata,
  input  logic        tx_axis_in_tvalid,
  output logic        tx_axis_in_tready,
  input  logic        tx_axis_in_tlast,
  output logic [7:0]  tx_axis_legacy_tdata,
  output logic        tx_axis_legacy_tvalid,
  input  logic        tx_axis_legacy_tready,
  output logic        tx_axis_legacy_tlast,
  output logic [7:0]  tx_axis_av_tdata,
  output logic        tx_axis_av_tvalid,
  input  logic        tx_axis_av_tready,
  output logic        tx_axis_av_tlast,
`ifdef TX_CLASSIFIER_STATS_EN
  output logic [31:0] av_frame_count,
  output logic [31:0] legacy_frame_count,
`endif
  output logic        frame_is_av,
  output logic        frame_class_valid
);

  localparam int CW = $clog2(HDR_LEN);
  localparam logic [CW-1:0] HDR_LAST = CW'(HDR_LEN - 1);

  typedef enum logic [1:0] {S_HDR, S_DECIDE, S_REPLAY, S_PASS} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   last_idx_q, last_idx_d;
  logic [7:0]      hdr_buf_q [HDR_LEN];
  logic [7:0]      hdr_buf_d [HDR_LEN];
  logic            short_q, short_d;
  logic            sel_q, sel_d;
  logic [7:0]      out_tdata_q, out_tdata_d;
  logic            out_tlast_q, out_tlast_d;
  logic            out_tvalid_q, out_tvalid_d;
  logic            frame_is_av_q, frame_is_av_d;
  logic            class_valid_q, class_valid_d;
  logic            rdy_q, rdy_d;
  logic            sel_tready;
  logic            av_dec;
  logic [CW-1:0]   final_idx;
  logic [CW-1:0]   idx_nxt;
`ifdef TX_CLASSIFIER_STATS_EN
  logic [31:0]     av_cnt_q, av_cnt_d;
  logic [31:0]     leg_cnt_q, leg_cnt_d;
`endif

  assign frame_is_av       = frame_is_av_q;
  assign frame_class_valid = class_valid_q;
`ifdef TX_CLASSIFIER_STATS_EN
  assign av_frame_count     = av_cnt_q;
  assign legacy_frame_count = leg_cnt_q;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    last_idx_d    = last_idx_q;
    hdr_buf_d     = hdr_buf_q;
    short_d       = short_q;
    sel_d         = sel_q;
    out_tdata_d   = out_tdata_q;
    out_tlast_d   = out_tlast_q;
    out_tvalid_d  = out_tvalid_q;
    frame_is_av_d = frame_is_av_q;
    class_valid_d = 1'b0;
    // Input ready stays low for the first cycle after reset releases.
    rdy_d         = 1'b1;
`ifdef TX_CLASSIFIER_STATS_EN
    av_cnt_d      = av_cnt_q;
    leg_cnt_d     = leg_cnt_q;
`endif

    tx_axis_in_tready     = 1'b0;
    tx_axis_legacy_tdata  = out_tdata_q;
    tx_axis_legacy_tlast  = out_tlast_q;
    tx_axis_legacy_tvalid = out_tvalid_q & ~sel_q;
    tx_axis_av_tdata      = out_tdata_q;
    tx_axis_av_tlast      = out_tlast_q;
    tx_axis_av_tvalid     = out_tvalid_q & sel_q;

    sel_tready = sel_q ? tx_axis_av_tready : tx_axis_legacy_tready;
    av_dec     = !short_q && ({hdr_buf_q[12], hdr_buf_q[13]} == VLAN_TPID)
                 && AV_PCP_MASK[hdr_buf_q[14][7:5]];
    final_idx  = short_q ? last_idx_q : HDR_LAST;
    idx_nxt    = idx_q + 1'b1;

    case (state_q)
      S_HDR: begin
        tx_axis_in_tready = rdy_q;
        if (tx_axis_in_tvalid && rdy_q) begin
          hdr_buf_d[cnt_q] = tx_axis_in_tdata;
          if (tx_axis_in_tlast || cnt_q == HDR_LAST) begin
            state_d    = S_DECIDE;
            short_d    = tx_axis_in_tlast;
            last_idx_d = cnt_q;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DECIDE: begin
        sel_d         = av_dec;
        frame_is_av_d = av_dec;
        class_valid_d = 1'b1;
        idx_d         = '0;
        out_tdata_d   = hdr_buf_q[0];
        out_tlast_d   = short_q && (last_idx_q == '0);
        out_tvalid_d  = 1'b1;
        state_d       = S_REPLAY;
`ifdef TX_CLASSIFIER_STATS_EN
        if (av_dec) av_cnt_d = av_cnt_q + 32'd1;
        else        leg_cnt_d = leg_cnt_q + 32'd1;
`endif
      end
      S_REPLAY: begin
        if (out_tvalid_q && sel_tready) begin
          if (idx_q == final_idx) begin
            out_tvalid_d = 1'b0;
            out_tlast_d  = 1'b0;
            state_d      = short_q ? S_HDR : S_PASS;
          end else begin
            idx_d       = idx_nxt;
            out_tdata_d = hdr_buf_q[idx_nxt];
            out_tlast_d = short_q && (idx_nxt == last_idx_q);
          end
        end
      end
      default: begin
        // Cut-through: the selected output is wired straight to the input.
        tx_axis_in_tready = sel_tready;
        if (sel_q) begin
          tx_axis_av_tdata  = tx_axis_in_tdata;
          tx_axis_av_tvalid = tx_axis_in_tvalid;
          tx_axis_av_tlast  = tx_axis_in_tlast;
        end else begin
          tx_axis_legacy_tdata  = tx_axis_in_tdata;
          tx_axis_legacy_tvalid = tx_axis_in_tvalid;
          tx_axis_legacy_tlast  = tx_axis_in_tlast;
        end
        if (tx_axis_in_tvalid && sel_tready && tx_axis_in_tlast) begin
          state_d = S_HDR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge tx_mac_aclk) begin
    if (tx_reset) begin
      state_q       <= S_HDR;
      cnt_q         <= '0;
      idx_q         <= '0;
      last_idx_q    <= '0;
      for (int i = 0; i < HDR_LEN; i++) hdr_buf_q[i] <= 8'h00;
      short_q       <= 1'b0;
      sel_q         <= 1'b0;
      out_tdata_q   <= 8'h00;
      out_tlast_q   <= 1'b0;
      out_tvalid_q  <= 1'b0;
      frame_is_av_q <= 1'b0;
      class_valid_q <= 1'b0;
      rdy_q         <= 1'b0;
`ifdef TX_CLASSIFIER_STATS_EN
      av_cnt_q      <= 32'd0;
      leg_cnt_q     <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
      hdr_buf_q     <= hdr_buf_d;
      short_q       <= short_d;
      sel_q         <= sel_d;
      out_tdata_q   <= out_tdata_d;
      out_tlast_q   <= out_tlast_d;
      out_tvalid_q  <= out_tvalid_d;
      frame_is_av_q <= frame_is_av_d;
      class_valid_q <= class_valid_d;
      rdy_q         <= rdy_d;
`ifdef TX_CLASSIFIER_STATS_EN
      av_cnt_q      <= av_cnt_d;
      leg_cnt_q     <= leg_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_traffic_classifier.sv
// tb/tb_tx_traffic_classifier.sv - directed-vector bench for tx_traffic_classifier.
module tb_tx_traffic_classifier;

  logic        clk = 1'b0;
  logic        tx_reset;
  logic [7:0]  in_tdata;
  logic        in_tvalid, in_tready, in_tlast;
  logic [7:0]  leg_tdata, av_tdata;
  logic        leg_tvalid, leg_tready, leg_tlast;
  logic        av_tvalid, av_tready, av_tlast;
  logic        frame_is_av, frame_class_valid;
`ifdef TX_CLASSIFIER_STATS_EN
  logic [31:0] av_frame_count, legacy_frame_count;
`endif

  always #5 clk = ~clk;

  tx_traffic_classifier dut (
    .tx_mac_aclk           (clk),
    .tx_reset              (tx_reset),
    .tx_axis_in_tdata      (in_tdata),
    .tx_axis_in_tvalid     (in_tvalid),
    .tx_axis_in_tready     (in_tready),
    .tx_axis_in_tlast      (in_tlast),
    .tx_axis_legacy_tdata  (leg_tdata),
    .tx_axis_legacy_tvalid (leg_tvalid),
    .tx_axis_legacy_tready (leg_tready),
    .tx_axis_legacy_tlast  (leg_tlast),
    .tx_axis_av_tdata      (av_tdata),
    .tx_axis_av_tvalid     (av_tvalid),
    .tx_axis_av_tready     (av_tready),
    .tx_axis_av_tlast      (av_tlast),
`ifdef TX_CLASSIFIER_STATS_EN
    .av_frame_count        (av_frame_count),
    .legacy_frame_count    (legacy_frame_count),
`endif
    .frame_is_av           (frame_is_av),
    .frame_class_valid     (frame_class_valid)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc, frame_acc, hdr_cyc, first_cyc;

  logic [8:0] in_q[$];
  logic [8:0] av_q[$];
  logic [8:0] leg_q[$];
  logic [8:0] exp_av[$];
  logic [8:0] exp_leg[$];
  logic       cls_q[$];
  logic       exp_cls[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int len, input logic [7:0] b12, input logic [7:0] b13,
                           input logic [7:0] b14, input logic [7:0] b15,
                           input logic to_av, input logic [7:0] seed);
    logic [7:0] b;
    logic [8:0] v;
    for (int i = 0; i < len; i++) begin
      b = seed + 8'(i);
      if (i == 12) b = b12;
      if (i == 13) b = b13;
      if (i == 14) b = b14;
      if (i == 15) b = b15;
      v = {(i == len - 1), b};
      in_q.push_back(v);
      if (to_av) exp_av.push_back(v);
      else       exp_leg.push_back(v);
    end
    exp_cls.push_back(to_av);
  endtask

  task automatic run(input bit toggle, input int stop_after);
    int idle = 0;
    int budget = 0;
    acc = 0; frame_acc = 0; hdr_cyc = -1; first_cyc = -1;
    forever begin
      @(negedge clk);
      if (stop_after > 0 && acc >= stop_after) begin
        in_tvalid = 1'b0;
        break;
      end
      if (in_q.size() > 0) begin
        in_tvalid = 1'b1;
        in_tdata  = in_q[0][7:0];
        in_tlast  = in_q[0][8];
      end else begin
        in_tvalid = 1'b0;
        in_tlast  = 1'b0;
      end
      av_tready  = toggle ? cyc[0] : 1'b1;
      leg_tready = 1'b1;
      #1;
      if (in_tvalid && in_tready) begin
        void'(in_q.pop_front());
        acc++;
        frame_acc++;
        if (frame_acc == 16 && hdr_cyc < 0) hdr_cyc = cyc;
        if (in_tlast) frame_acc = 0;
      end
      if ((av_tvalid || leg_tvalid) && hdr_cyc >= 0 && first_cyc < 0) first_cyc = cyc;
      if (av_tvalid && av_tready) av_q.push_back({av_tlast, av_tdata});
      if (leg_tvalid && leg_tready) leg_q.push_back({leg_tlast, leg_tdata});
      if (frame_class_valid) cls_q.push_back(frame_is_av);
      idle = (in_q.size() == 0 && !av_tvalid && !leg_tvalid) ? idle + 1 : 0;
      cyc++;
      budget++;
      if (idle >= 6) break;
      if (budget > 5000) begin
        chk("run_timeout", 32'(budget), 32'd0);
        break;
      end
    end
    in_tvalid  = 1'b0;
    av_tready  = 1'b1;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_av_len"}, 32'(av_q.size()), 32'(exp_av.size()));
    for (int i = 0; i < av_q.size() && i < exp_av.size(); i++)
      chk({tag, "_av_byte"}, 32'(av_q[i]), 32'(exp_av[i]));
    chk({tag, "_leg_len"}, 32'(leg_q.size()), 32'(exp_leg.size()));
    for (int i = 0; i < leg_q.size() && i < exp_leg.size(); i++)
      chk({tag, "_leg_byte"}, 32'(leg_q[i]), 32'(exp_leg[i]));
    chk({tag, "_cls_len"}, 32'(cls_q.size()), 32'(exp_cls.size()));
    for (int i = 0; i < cls_q.size() && i < exp_cls.size(); i++)
      chk({tag, "_cls"}, 32'(cls_q[i]), 32'(exp_cls[i]));
    av_q.delete(); leg_q.delete(); cls_q.delete();
    exp_av.delete(); exp_leg.delete(); exp_cls.delete();
  endtask

  initial begin
    tx_reset   = 1'b1;
    in_tdata   = 8'h00;
    in_tvalid  = 1'b0;
    in_tlast   = 1'b0;
    av_tready  = 1'b1;
    leg_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_tready",   32'(in_tready), 32'd0);
    chk("rst_av_tvalid",   32'(av_tvalid), 32'd0);
    chk("rst_leg_tvalid",  32'(leg_tvalid), 32'd0);
    chk("rst_av_tdata",    32'(av_tdata), 32'd0);
    chk("rst_leg_tdata",   32'(leg_tdata), 32'd0);
    chk("rst_av_tlast",    32'(av_tlast), 32'd0);
    chk("rst_leg_tlast",   32'(leg_tlast), 32'd0);
    chk("rst_is_av",       32'(frame_is_av), 32'd0);
    chk("rst_class_valid", 32'(frame_class_valid), 32'd0);
`ifdef TX_CLASSIFIER_STATS_EN
    chk("rst_av_count",  av_frame_count, 32'd0);
    chk("rst_leg_count", legacy_frame_count, 32'd0);
`endif
    @(negedge clk);
    tx_reset = 1'b0;

    // PCP 3 tagged, 64 bytes: AV, 2-cycle decision latency
    add_frame(64, 8'h81, 8'h00, 8'h60, 8'h00, 1'b1, 8'h10);
    run(1'b0, 0);
    chk("latency", 32'(first_cyc - hdr_cyc), 32'd2);
    compare("av64");

    // untagged IPv4 ethertype: legacy
    add_frame(64, 8'h08, 8'h00, 8'h45, 8'h00, 1'b0, 8'h40);
    run(1'b0, 0);
    compare("untag64");

    // PCP 0 then PCP 2 back to back
    add_frame(40, 8'h81, 8'h00, 8'h00, 8'h05, 1'b0, 8'h80);
    add_frame(30, 8'h81, 8'h00, 8'h40, 8'h00, 1'b1, 8'hA0);
    run(1'b0, 0);
    compare("b2b");

    // 10-byte short frame followed by a tagged AV frame
    add_frame(10, 8'h81, 8'h00, 8'h60, 8'h00, 1'b0, 8'h20);
    add_frame(64, 8'h81, 8'h00, 8'h60, 8'h00, 1'b1, 8'h30);
    run(1'b0, 0);
    compare("short10");

    // exactly header length: short, tlast replayed on byte 16
    add_frame(16, 8'h81, 8'h00, 8'h60, 8'h00, 1'b0, 8'h50);
    run(1'b0, 0);
    compare("exact16");

    // AV backpressure toggling through replay and pass
    add_frame(40, 8'h81, 8'h00, 8'h6F, 8'hFF, 1'b1, 8'hC0);
    run(1'b1, 0);
    compare("toggle");

    // reset at byte 30 of a 100-byte AV frame
    add_frame(100, 8'h81, 8'h00, 8'h60, 8'h00, 1'b1, 8'h00);
    run(1'b0, 30);
    tx_reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_in_tready",  32'(in_tready), 32'd0);
    chk("mid_rst_av_tvalid",  32'(av_tvalid), 32'd0);
    chk("mid_rst_leg_tvalid", 32'(leg_tvalid), 32'd0);
    chk("mid_rst_is_av",      32'(frame_is_av), 32'd0);
    in_q.delete(); av_q.delete(); leg_q.delete(); cls_q.delete();
    exp_av.delete(); exp_leg.delete(); exp_cls.delete();
    @(negedge clk);
    tx_reset = 1'b0;
`ifdef TX_CLASSIFIER_STATS_EN
    chk("mid_rst_av_count",  av_frame_count, 32'd0);
    chk("mid_rst_leg_count", legacy_frame_count, 32'd0);
`endif
    add_frame(64, 8'h08, 8'h06, 8'h00, 8'h01, 1'b0, 8'h70);
    run(1'b0, 0);
    compare("post_rst");
`ifdef TX_CLASSIFIER_STATS_EN
    chk("post_av_count",  av_frame_count, 32'd0);
    chk("post_leg_count", legacy_frame_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
